load_data_unit: RTL

Memory-read stage directly upstream of the writeback select mux. Sequences one load from 64-bit data memory: issues the read strobe, waits the fixed memory latency, then captures the doubleword. It selects the addressed byte, halfword or word and sign- or zero-extends it. The result is held in a register that feeds the writeback mux's memory-data input. Misaligned and illegal loads are reported without touching memory.

---
 rtl/load_pkg.sv | 36 +++
 rtl/load_extend.sv | 30 +++
 rtl/load_data_unit.sv | 89 ++++++++
 3 files changed

// File: rtl/load_pkg.sv
// Shared types and helpers for the load data unit.
// Holds the load-type and FSM state encodings plus the alignment check.
package load_pkg;

  typedef enum logic [2:0] {
    LB      = 3'd0,
    LH      = 3'd1,
    LW      = 3'd2,
    LD      = 3'd3,
    LBU     = 3'd4,
    LHU     = 3'd5,
    LWU     = 3'd6,
    ILLEGAL = 3'd7
  } funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  // True when the load type is defined and the offset is naturally aligned.
  function automatic logic load_legal(funct3_t f, logic [2:0] a);
    logic ok;
    ok = 1'b0;
    case (f)
      LB, LBU: ok = 1'b1;
      LH, LHU: ok = (a[0] == 1'b0);
      LW, LWU: ok = (a[1:0] == 2'b00);
      LD:      ok = (a == 3'b000);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational byte/half/word/double select and sign/zero extension.
// Ports: mem_data (64b doubleword), addr_low (byte offset), funct3 -> data.
module load_extend
  import load_pkg::*;
(
  input  logic [63:0] mem_data,
  input  logic [2:0]  addr_low,
  input  funct3_t     funct3,
  output logic [63:0] data
);

  logic [63:0] sh;

  always_comb begin
    // Little-endian: the addressed byte lands in bit 0 after the shift.
    sh   = mem_data >> {addr_low, 3'b000};
    data = sh;
    case (funct3)
      LB:      data = {{56{sh[7]}}, sh[7:0]};
      LH:      data = {{48{sh[15]}}, sh[15:0]};
      LW:      data = {{32{sh[31]}}, sh[31:0]};
      LD:      data = sh;
      LBU:     data = {56'd0, sh[7:0]};
      LHU:     data = {48'd0, sh[15:0]};
      LWU:     data = {32'd0, sh[31:0]};
      default: data = sh;
    endcase
  end

endmodule

// File: rtl/load_data_unit.sv
// Load sequencer: strobes memory, waits MEM_LATENCY, captures and extends.
// Ports: START/FUNCT3/ADDR_LOW/MEM_DATA in; MEM_RD/BUSY/DONE/ERR/LOAD_DATA out.
module load_data_unit
  import load_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int DATA_W      = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              START,
  input  logic [2:0]        FUNCT3,
  input  logic [2:0]        ADDR_LOW,
  input  logic [DATA_W-1:0] MEM_DATA,
  output logic              MEM_RD,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [DATA_W-1:0] LOAD_DATA
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  state_t            state;
  logic [CW-1:0]     cnt;
  funct3_t           f3_q;
  logic [2:0]        addr_q;
  logic [DATA_W-1:0] ext;

  // Extension works on the latched request, so inputs may change mid-load.
  load_extend u_ext (
    .mem_data (MEM_DATA),
    .addr_low (addr_q),
    .funct3   (f3_q),
    .data     (ext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      f3_q      <= LB;
      addr_q    <= 3'd0;
      MEM_RD    <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      LOAD_DATA <= '0;
    end else begin
      MEM_RD <= 1'b0;
      DONE   <= 1'b0;
      ERR    <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            f3_q   <= funct3_t'(FUNCT3);
            addr_q <= ADDR_LOW;
            if (load_legal(funct3_t'(FUNCT3), ADDR_LOW)) begin
              state  <= REQ;
              MEM_RD <= 1'b1;
              BUSY   <= 1'b1;
            end else begin
              ERR <= 1'b1;
            end
          end
        end
        REQ: begin
          cnt   <= CW'(MEM_LATENCY - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            LOAD_DATA <= ext;
            DONE      <= 1'b1;
            BUSY      <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule
